// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner. It drives one row low at a time and samples the
// synchronized columns at the end of each row dwell. A press or a release is
// accepted only after DEB_N consecutive identical samples. One key at a time:
// while a key is held, the scan stays parked on that key's row.
module keypad_scan #(
    parameter int SCAN_CYCLES = 4,
    parameter int DEB_N       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] rows,
    input  logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DW = $clog2(SCAN_CYCLES);
    localparam int CW = (DEB_N > 1) ? $clog2(DEB_N + 1) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEB_N);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [1:0]      r, r_n;
    logic [DW-1:0]   dwell;
    logic [3:0]      cs_meta, cs;
    logic [3:0]      p, p_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [3:0]      key_n;
    logic            key_valid_n;
    logic            key_down_n;
    logic            sample;

    // Column index of the lowest pulled-low column (lowest index wins).
    function automatic logic [1:0] low_zero(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (!v[0])      idx = 2'd0;
        else if (!v[1]) idx = 2'd1;
        else if (!v[2]) idx = 2'd2;
        else if (!v[3]) idx = 2'd3;
        return idx;
    endfunction

    assign rows   = ~(4'b0001 << r);
    assign sample = (dwell == DWELL_MAX);

    // Two-flop synchronizer for the asynchronous column inputs (idle = all high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta <= 4'hF;
            cs      <= 4'hF;
        end else begin
            cs_meta <= cols;
            cs      <= cs_meta;
        end
    end

    // Row dwell counter. The row index only moves at a sample point, so
    // wrapping here also restarts the dwell on every row change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell <= '0;
        end else if (sample) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    // Next-state and output decode; every decision happens at a sample point.
    // The key code is built from cs, which equals the latched pattern whenever
    // a press is accepted.
    always_comb begin
        state_n     = state;
        r_n         = r;
        p_n         = p;
        cnt_n       = cnt;
        key_n       = key;
        key_valid_n = 1'b0;
        key_down_n  = key_down;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (cs == 4'hF) begin
                        r_n = r + 2'd1;
                    end else begin
                        p_n   = cs;
                        cnt_n = CW'(1);
                        if (DEB_N == 1) begin
                            key_n       = {r, low_zero(cs)};
                            key_valid_n = 1'b1;
                            key_down_n  = 1'b1;
                            state_n     = HELD;
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (cs == p) begin
                        cnt_n = cnt + CW'(1);
                        if (cnt + CW'(1) == CNT_DONE) begin
                            key_n       = {r, low_zero(cs)};
                            key_valid_n = 1'b1;
                            key_down_n  = 1'b1;
                            state_n     = HELD;
                        end
                    end else begin
                        r_n     = r + 2'd1;
                        state_n = SCAN;
                    end
                end
                HELD: begin
                    if (cs == 4'hF) begin
                        cnt_n = CW'(1);
                        if (DEB_N == 1) begin
                            key_down_n = 1'b0;
                            r_n        = r + 2'd1;
                            state_n    = SCAN;
                        end else begin
                            state_n = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (cs == 4'hF) begin
                        cnt_n = cnt + CW'(1);
                        if (cnt + CW'(1) == CNT_DONE) begin
                            key_down_n = 1'b0;
                            r_n        = r + 2'd1;
                            state_n    = SCAN;
                        end
                    end else begin
                        state_n = HELD;
                    end
                end
                default: begin
                    state_n = SCAN;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            r         <= 2'd0;
            p         <= 4'hF;
            cnt       <= '0;
            key       <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_n;
            r         <= r_n;
            p         <= p_n;
            cnt       <= cnt_n;
            key       <= key_n;
            key_valid <= key_valid_n;
            key_down  <= key_down_n;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan (SCAN_CYCLES = 4, DEB_N = 3). A switch-matrix model
// pulls a column low whenever a pressed key's row is being driven.
module tb_keypad_scan;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_down;
    logic [15:0] mask;

    int checks;
    int errors;
    int pulses;
    int consec_err;
    int key_chg_err;
    logic prev_kv;
    logic [3:0] prev_key;

    typedef struct {
        logic [15:0] mask;
        logic [3:0]  exp_key;
    } vec_t;

    vec_t vecs[6];

    keypad_scan #(.SCAN_CYCLES(4), .DEB_N(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch matrix: bit row*4+col of mask closed.
    always_comb begin
        cols = 4'hF;
        for (int rr = 0; rr < 4; rr++) begin
            if (!rows[rr]) begin
                for (int cc = 0; cc < 4; cc++) begin
                    if (mask[rr * 4 + cc]) cols[cc] = 1'b0;
                end
            end
        end
    end

    // Per-cycle observers: pulse count, back-to-back pulses, key changes without a pulse.
    initial begin
        pulses      = 0;
        consec_err  = 0;
        key_chg_err = 0;
        prev_kv     = 1'b0;
        prev_key    = 4'd0;
    end
    always @(posedge clk) begin
        #1;
        if (key_valid) pulses++;
        if (key_valid && prev_kv) consec_err++;
        if (rst_n && !key_valid && (key !== prev_key)) key_chg_err++;
        prev_kv  = key_valid;
        prev_key = key;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Return at the first negedge of a fresh dwell on the target row.
    task automatic wait_row(input logic [3:0] target);
        int n;
        n = 0;
        while (rows == target && n < 40) begin
            @(negedge clk);
            n++;
        end
        while (rows != target && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("wait_row_timeout", (rows == target), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int p0;
        int n;
        wait_row(4'b1110);
        p0   = pulses;
        mask = v.mask;
        repeat (40) @(negedge clk);
        check("vec_pulse_count", pulses - p0, 1);
        check("vec_key", key, v.exp_key);
        check("vec_key_down_held", key_down, 1);
        mask = 16'h0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("vec_key_down_early", key_down, 1);
        n = 0;
        while (key_down && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("vec_key_down_cleared", key_down, 0);
        check("vec_key_retained", key, v.exp_key);
        check("vec_no_pulse_on_release", pulses - p0, 1);
    endtask

    initial begin
        int p0;
        int n;
        logic down_ok;
        checks = 0;
        errors = 0;
        mask   = 16'h0;
        rst_n  = 1'b0;

        vecs[0] = '{mask: 16'h0040, exp_key: 4'd6};   // row 1 col 2
        vecs[1] = '{mask: 16'h000A, exp_key: 4'd1};   // row 0 cols 1 and 3
        vecs[2] = '{mask: 16'h8000, exp_key: 4'd15};  // row 3 col 3
        vecs[3] = '{mask: 16'h0001, exp_key: 4'd0};   // row 0 col 0
        vecs[4] = '{mask: 16'h0110, exp_key: 4'd4};   // rows 1 and 2: row 1 seen first
        vecs[5] = '{mask: 16'h0600, exp_key: 4'd9};   // row 2 cols 1 and 2

        // Reset values.
        repeat (3) @(negedge clk);
        check("reset_rows", rows, 4'b1110);
        check("reset_key", key, 0);
        check("reset_key_valid", key_valid, 0);
        check("reset_key_down", key_down, 0);

        // Idle scan: four cycles per row from row 0.
        rst_n = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 64; i++) begin
            logic [3:0] exp_rows;
            exp_rows = ~(4'b0001 << ((i / 4) % 4));
            check("idle_rows", rows, exp_rows);
            @(negedge clk);
        end
        check("idle_no_pulse", pulses - p0, 0);

        // Bounce: row 3 col 0 seen for a single sample, then open.
        wait_row(4'b0111);
        p0   = pulses;
        mask = 16'h1000;
        repeat (4) @(posedge clk);
        @(negedge clk);
        mask = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bounce_rows_held", rows, 4'b0111);
        @(posedge clk);
        @(negedge clk);
        check("bounce_rows_restart", rows, 4'b1110);
        repeat (20) @(negedge clk);
        check("bounce_no_pulse", pulses - p0, 0);

        // Table of presses.
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Release glitch on key 5: two high samples then pressed again.
        p0   = pulses;
        mask = 16'h0020;
        n = 0;
        while (!key_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("glitch_accept", key_valid, 1);
        check("glitch_key", key, 5);
        @(posedge clk);
        @(negedge clk);
        mask = 16'h0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        mask = 16'h0020;
        down_ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (!key_down) down_ok = 1'b0;
        end
        check("glitch_key_down_kept", down_ok, 1);
        check("glitch_single_pulse", pulses - p0, 1);
        mask = 16'h0;
        n = 0;
        while (key_down && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("glitch_full_release", key_down, 0);

        // Reset during the second matching sample of a row 0 press.
        wait_row(4'b1110);
        p0   = pulses;
        mask = 16'h0001;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        mask  = 16'h0;
        #1;
        check("midreset_rows", rows, 4'b1110);
        check("midreset_key", key, 0);
        check("midreset_key_valid", key_valid, 0);
        check("midreset_key_down", key_down, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postreset_rows", rows, 4'b1110);
        repeat (40) @(negedge clk);
        check("midreset_no_pulse", pulses - p0, 0);
        check("postreset_key", key, 0);

        check("key_valid_back_to_back", consec_err, 0);
        check("key_changed_without_pulse", key_chg_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
